// File: rtl/armleocpu_cache_pagefault_check.sv
// Sv32 page fault checker for the cache. Decides, from the current CSR state, the
// command and the TLB-provided PTE flags, whether the access faults. Also provides
// an ASCII reason string and a registered copy of the fault flag.
module armleocpu_cache_pagefault_check (
  input  logic         clk,
  input  logic         rst,

  input  logic         csr_satp_mode_r,
  input  logic         csr_mstatus_mprv,
  input  logic         csr_mstatus_mxr,
  input  logic         csr_mstatus_sum,
  input  logic [1:0]   csr_mstatus_mpp,
  input  logic [1:0]   csr_mcurrent_privilege,

  input  logic [3:0]   os_cmd,
  input  logic [7:0]   tlb_read_metadata,

  output logic         pagefault,
  output logic [239:0] reason,
  output logic         pagefault_r
);

  // Privilege encodings
  localparam logic [1:0] PrivUser       = 2'd0;
  localparam logic [1:0] PrivSupervisor = 2'd1;
  localparam logic [1:0] PrivMachine    = 2'd3;

  // Cache command encodings
  localparam logic [3:0] CacheCmdNone    = 4'd0;
  localparam logic [3:0] CacheCmdExecute = 4'd1;
  localparam logic [3:0] CacheCmdLoad    = 4'd2;
  localparam logic [3:0] CacheCmdStore   = 4'd3;

  // Reason strings: 30 characters, left-justified, space-padded
  localparam logic [239:0] RsnNone         = {"NONE",                 {26{8'h20}}};
  localparam logic [239:0] RsnInvalid      = {"INVALID",              {23{8'h20}}};
  localparam logic [239:0] RsnWriteNoRead  = {"WRITE_WITHOUT_READ",   {12{8'h20}}};
  localparam logic [239:0] RsnNotLeaf      = {"NOT_LEAF",             {22{8'h20}}};
  localparam logic [239:0] RsnSupUserPage  = {"SUPERVISOR_USER_PAGE", {10{8'h20}}};
  localparam logic [239:0] RsnUserSupPage  = {"USER_SUPERVISOR_PAGE", {10{8'h20}}};
  localparam logic [239:0] RsnAccessZero   = {"ACCESS_ZERO",          {19{8'h20}}};
  localparam logic [239:0] RsnDirtyZero    = {"DIRTY_ZERO",           {20{8'h20}}};
  localparam logic [239:0] RsnNotExec      = {"NOT_EXECUTABLE",       {16{8'h20}}};
  localparam logic [239:0] RsnNotWritable  = {"NOT_WRITABLE",         {18{8'h20}}};
  localparam logic [239:0] RsnNotReadable  = {"NOT_READABLE",         {18{8'h20}}};

  // PTE flag decode (G, bit 5, is intentionally unused)
  logic w_v, w_r, w_w, w_x, w_u, w_a, w_d;
  assign w_v = tlb_read_metadata[0];
  assign w_r = tlb_read_metadata[1];
  assign w_w = tlb_read_metadata[2];
  assign w_x = tlb_read_metadata[3];
  assign w_u = tlb_read_metadata[4];
  assign w_a = tlb_read_metadata[6];
  assign w_d = tlb_read_metadata[7];

  logic       w_unused_g;
  assign w_unused_g = tlb_read_metadata[5];

  logic [1:0] w_eff_priv;
  assign w_eff_priv = csr_mstatus_mprv ? csr_mstatus_mpp : csr_mcurrent_privilege;

  logic w_is_load, w_is_store, w_is_exec, w_is_access;
  assign w_is_load   = (os_cmd == CacheCmdLoad);
  assign w_is_store  = (os_cmd == CacheCmdStore);
  assign w_is_exec   = (os_cmd == CacheCmdExecute);
  assign w_is_access = w_is_load || w_is_store || w_is_exec;

  logic w_check_en;
  assign w_check_en = csr_satp_mode_r && (w_eff_priv != PrivMachine) && w_is_access;

  logic w_cmd_none_unused;
  assign w_cmd_none_unused = (os_cmd == CacheCmdNone);

  // Prioritised fault checks; first failing check wins
  always_comb begin
    pagefault = 1'b0;
    reason    = RsnNone;
    if (w_check_en) begin
      if (!w_v) begin
        pagefault = 1'b1;
        reason    = RsnInvalid;
      end else if (!w_r && w_w) begin
        pagefault = 1'b1;
        reason    = RsnWriteNoRead;
      end else if (!w_r && !w_w && !w_x) begin
        pagefault = 1'b1;
        reason    = RsnNotLeaf;
      end else if (w_u && (w_eff_priv == PrivSupervisor) && !csr_mstatus_sum) begin
        pagefault = 1'b1;
        reason    = RsnSupUserPage;
      end else if (!w_u && (w_eff_priv == PrivUser)) begin
        pagefault = 1'b1;
        reason    = RsnUserSupPage;
      end else if (!w_a) begin
        pagefault = 1'b1;
        reason    = RsnAccessZero;
      end else if (w_is_store && !w_d) begin
        pagefault = 1'b1;
        reason    = RsnDirtyZero;
      end else if (w_is_exec && !w_x) begin
        pagefault = 1'b1;
        reason    = RsnNotExec;
      end else if (w_is_store && !w_w) begin
        pagefault = 1'b1;
        reason    = RsnNotWritable;
      end else if (w_is_load && !w_r && !(csr_mstatus_mxr && w_x)) begin
        pagefault = 1'b1;
        reason    = RsnNotReadable;
      end
    end
  end

  logic r_pagefault;

  // Registered fault flag, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pagefault <= 1'b0;
    end else begin
      r_pagefault <= pagefault;
    end
  end

  assign pagefault_r = r_pagefault;

endmodule

// File: tb/tb_armleocpu_cache_pagefault_check.sv
// Self-checking bench: directed vector table, reset sequence, and randomized
// stimulus against a rule-list reference model.
module tb_armleocpu_cache_pagefault_check;

  logic         clk;
  logic         rst;
  logic         satp, mprv, mxr, sum;
  logic [1:0]   mpp, priv;
  logic [3:0]   cmd;
  logic [7:0]   meta;
  logic         pagefault;
  logic [239:0] reason;
  logic         pagefault_r;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] CNone = 4'd0, CExec = 4'd1, CLoad = 4'd2, CStore = 4'd3;
  localparam logic [1:0] PU = 2'd0, PS = 2'd1, PM = 2'd3;

  armleocpu_cache_pagefault_check dut (
    .clk                    (clk),
    .rst                    (rst),
    .csr_satp_mode_r        (satp),
    .csr_mstatus_mprv       (mprv),
    .csr_mstatus_mxr        (mxr),
    .csr_mstatus_sum        (sum),
    .csr_mstatus_mpp        (mpp),
    .csr_mcurrent_privilege (priv),
    .os_cmd                 (cmd),
    .tlb_read_metadata      (meta),
    .pagefault              (pagefault),
    .reason                 (reason),
    .pagefault_r            (pagefault_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string rule_name [10] = '{"INVALID", "WRITE_WITHOUT_READ", "NOT_LEAF",
                            "SUPERVISOR_USER_PAGE", "USER_SUPERVISOR_PAGE", "ACCESS_ZERO",
                            "DIRTY_ZERO", "NOT_EXECUTABLE", "NOT_WRITABLE", "NOT_READABLE"};

  function automatic logic [239:0] pad(input string s);
    logic [239:0] v;
    v = {30{8'h20}};
    for (int i = 0; i < s.len() && i < 30; i++) v[239 - 8*i -: 8] = s[i];
    return v;
  endfunction

  // Evaluates every rule independently, then reports the highest-priority violation
  // (-1 when the access is allowed or not subject to translation).
  function automatic int model(input logic s_satp, input logic s_mprv, input logic s_mxr,
                               input logic s_sum, input logic [1:0] s_mpp,
                               input logic [1:0] s_priv, input logic [3:0] s_cmd,
                               input logic [7:0] m);
    logic [1:0] ep;
    bit ld, st, ex;
    bit viol [10];
    bit V, R, W, X, U, A, D;
    ep = s_mprv ? s_mpp : s_priv;
    ld = (s_cmd == CLoad); st = (s_cmd == CStore); ex = (s_cmd == CExec);
    if (!s_satp || ep == PM || !(ld || st || ex)) return -1;
    {D, A, U, X, W, R, V} = {m[7], m[6], m[4], m[3], m[2], m[1], m[0]};
    viol[0] = !V;
    viol[1] = !R && W;
    viol[2] = !R && !W && !X;
    viol[3] = U && ep == PS && !s_sum;
    viol[4] = !U && ep == PU;
    viol[5] = !A;
    viol[6] = st && !D;
    viol[7] = ex && !X;
    viol[8] = st && !W;
    viol[9] = ld && !R && !(s_mxr && X);
    for (int i = 0; i < 10; i++) if (viol[i]) return i;
    return -1;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_reason(input string name, input string exp);
    checks++;
    if (reason !== pad(exp)) begin
      failures++;
      $display("FAIL %s: reason got \"%s\" expected \"%s\"", name, reason, exp);
    end
  endtask

  typedef struct {
    logic       satp, mprv, mxr, sum;
    logic [1:0] mpp, priv;
    logic [3:0] cmd;
    logic [7:0] meta;
    logic       exp_pf;
    string      exp_rsn;  // empty: reason not checked
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic s, input logic sm, input logic [1:0] pv, input logic x,
                     input logic [3:0] c, input logic [7:0] m, input logic pf,
                     input string r);
    vec_t v;
    v.satp = s; v.mprv = 1'b0; v.mxr = x; v.sum = sm; v.mpp = PU; v.priv = pv;
    v.cmd = c; v.meta = m; v.exp_pf = pf; v.exp_rsn = r;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    satp = v.satp; mprv = v.mprv; mxr = v.mxr; sum = v.sum;
    mpp = v.mpp; priv = v.priv; cmd = v.cmd; meta = v.meta;
  endtask

  initial begin
    vec_t v;
    logic [3:0] cmds [3] = '{CLoad, CStore, CExec};
    int exp_idx;
    logic prev_pf;

    // Machine mode never faults
    add(1'b0, 1'b0, PM, 1'b0, CLoad,  8'h00, 1'b0, "NONE");
    add(1'b1, 1'b0, PM, 1'b0, CStore, 8'h00, 1'b0, "NONE");
    add(1'b1, 1'b0, PM, 1'b0, CExec,  8'hfe, 1'b0, "NONE");
    // Supervisor on U page
    add(1'b1, 1'b0, PS, 1'b0, CLoad,  8'b1101_1111, 1'b1, "SUPERVISOR_USER_PAGE");
    add(1'b1, 1'b1, PS, 1'b0, CExec,  8'b1101_1111, 1'b0, "NONE");
    add(1'b1, 1'b1, PS, 1'b0, CLoad,  8'b1101_1111, 1'b0, "NONE");
    add(1'b1, 1'b1, PS, 1'b0, CStore, 8'b1101_1111, 1'b0, "NONE");
    // User permission cases
    add(1'b1, 1'b0, PU, 1'b0, CExec,  8'b1101_0111, 1'b1, "NOT_EXECUTABLE");
    add(1'b1, 1'b0, PU, 1'b0, CExec,  8'b1101_1001, 1'b0, "NONE");
    add(1'b1, 1'b0, PU, 1'b0, CStore, 8'b1101_1011, 1'b1, "NOT_WRITABLE");
    add(1'b1, 1'b0, PU, 1'b0, CStore, 8'b1101_0111, 1'b0, "NONE");
    add(1'b1, 1'b0, PU, 1'b0, CLoad,  8'b1101_1001, 1'b1, "NOT_READABLE");
    add(1'b1, 1'b0, PU, 1'b0, CLoad,  8'b1101_0011, 1'b0, "NONE");
    // MXR
    add(1'b1, 1'b0, PU, 1'b1, CLoad,  8'b1101_1001, 1'b0, "NONE");
    // D=0 / A=0
    add(1'b1, 1'b0, PU, 1'b0, CLoad,  8'b0101_1111, 1'b0, "NONE");
    add(1'b1, 1'b0, PU, 1'b0, CStore, 8'b0101_1111, 1'b1, "DIRTY_ZERO");
    add(1'b1, 1'b0, PU, 1'b0, CExec,  8'b0101_1111, 1'b0, "NONE");
    for (int i = 0; i < 3; i++)
      add(1'b1, 1'b0, PU, 1'b0, cmds[i], 8'b1001_1111, 1'b1, "ACCESS_ZERO");
    // Invalid vs fully-permitted, user and supervisor with SUM
    for (int i = 0; i < 3; i++) begin
      add(1'b1, 1'b0, PU, 1'b0, cmds[i], 8'b1101_1110, 1'b1, "INVALID");
      add(1'b1, 1'b1, PS, 1'b0, cmds[i], 8'b1101_1110, 1'b1, "INVALID");
      add(1'b1, 1'b0, PU, 1'b0, cmds[i], 8'b1101_1111, 1'b0, "NONE");
      add(1'b1, 1'b1, PS, 1'b0, cmds[i], 8'b1101_1111, 1'b0, "NONE");
    end
    // Other priority stops, G ignored, non-access command
    add(1'b1, 1'b0, PU, 1'b0, CLoad,  8'b1101_0101, 1'b1, "WRITE_WITHOUT_READ");
    add(1'b1, 1'b0, PU, 1'b0, CLoad,  8'b1101_0001, 1'b1, "NOT_LEAF");
    add(1'b1, 1'b0, PU, 1'b0, CLoad,  8'b1100_1111, 1'b1, "USER_SUPERVISOR_PAGE");
    add(1'b1, 1'b0, PU, 1'b0, CLoad,  8'b1111_1111, 1'b0, "NONE");
    add(1'b1, 1'b0, PU, 1'b0, CNone,  8'b0000_0000, 1'b0, "NONE");
    add(1'b1, 1'b0, PU, 1'b0, 4'd4,   8'b0000_0000, 1'b0, "NONE");

    // Reset sequence with a faulting input held throughout
    rst = 1'b1;
    v = vecs[3];
    drive(v);
    @(posedge clk); #1;
    check_bit("reset_pagefault_r", pagefault_r, 1'b0);
    check_bit("reset_no_effect_comb", pagefault, 1'b1);
    check_reason("reset_no_effect_reason", "SUPERVISOR_USER_PAGE");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check_bit("post_reset_pagefault_r", pagefault_r, 1'b1);

    // MPRV selects MPP: machine current privilege acting as user
    @(negedge clk);
    satp = 1'b1; mprv = 1'b1; mpp = PU; priv = PM; sum = 1'b0; mxr = 1'b0;
    cmd = CLoad; meta = 8'b1100_1111;
    #1;
    check_bit("mprv_user_pf", pagefault, 1'b1);
    check_reason("mprv_user_rsn", "USER_SUPERVISOR_PAGE");
    mpp = PM; priv = PU;
    #1;
    check_bit("mprv_machine_pf", pagefault, 1'b0);

    // Directed table
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_bit($sformatf("vec%0d_pf", i), pagefault, vecs[i].exp_pf);
      if (vecs[i].exp_rsn.len() != 0) check_reason($sformatf("vec%0d_rsn", i), vecs[i].exp_rsn);
      @(posedge clk); #1;
      check_bit($sformatf("vec%0d_pf_r", i), pagefault_r, vecs[i].exp_pf);
    end

    // Randomized against the reference model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      satp = ($urandom_range(0, 7) != 0);
      mprv = $urandom_range(0, 1);
      mxr  = $urandom_range(0, 1);
      sum  = $urandom_range(0, 1);
      mpp  = 2'($urandom_range(0, 3));
      priv = 2'($urandom_range(0, 3));
      cmd  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                         : 4'($urandom_range(1, 3));
      meta = 8'($urandom) | (($urandom_range(0, 1) != 0) ? 8'hc1 : 8'h00);
      #1;
      exp_idx = model(satp, mprv, mxr, sum, mpp, priv, cmd, meta);
      prev_pf = (exp_idx >= 0);
      check_bit($sformatf("rnd%0d_pf", n), pagefault, prev_pf);
      check_reason($sformatf("rnd%0d_rsn", n), (exp_idx >= 0) ? rule_name[exp_idx] : "NONE");
      @(posedge clk); #1;
      check_bit($sformatf("rnd%0d_pf_r", n), pagefault_r, prev_pf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
